// File: rtl/clk_en_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clk_en_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

   localparam int ACC_W_DEF = 16;
   localparam int CNT_W     = 8;

endpackage

// File: rtl/cen_chan.sv
// One channel divider: turns every DIV-th base tick into a one-cycle enable.
module cen_chan
   import clk_en_pkg::*;
#(
   parameter int DIV    = 1,
   parameter int OFFSET = 0
) (
   input  logic ref_clk,
   input  logic reset_n,
   input  logic tick,
   input  logic hold,
   output logic cen,
   output logic fire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Combinational look-ahead of cen, so the pause FSM can stop on this boundary.
   assign fire = tick && !hold && (cnt == LAST);

   always_ff @(posedge ref_clk) begin
      if (!reset_n) begin
         cnt <= CNT_W'(OFFSET);
         cen <= 1'b0;
      end else if (hold || !tick) begin
         cen <= 1'b0;
      end else begin
         cen <= (cnt == LAST);
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cen_scheduler.sv
// Fractional base-tick generator with three phased channel enables,
// a shadowed rate config and a pause handshake aligned to CPU enables.
module cen_scheduler
   import clk_en_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int NUM_DEF = 1,
   parameter int DEN_DEF = 12,
   parameter int DIV_A   = 1,
   parameter int DIV_B   = 2,
   parameter int DIV_C   = 4,
   parameter int OFF_A   = 0,
   parameter int OFF_B   = 0,
   parameter int OFF_C   = 0
) (
   input  logic             ref_clk,
   input  logic             reset_n,
   input  logic             cfg_we,
   input  logic [ACC_W-1:0] cfg_num,
   input  logic [ACC_W-1:0] cfg_den,
   output logic             cfg_pending,
   output logic             cfg_err,
   input  logic             pause_req,
   output logic             pause_ack,
   output logic             cen_base,
   output logic             cen_a,
   output logic             cen_b,
   output logic             cen_c
);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] num, den, acc, sh_num, sh_den;
   logic [ACC_W:0]   sum;
   logic             tick, hold, cfg_bad;
   logic             fire_a, unused_fire_b, unused_fire_c;

   assign hold    = (state == PAUSED);
   assign sum     = {1'b0, acc} + {1'b0, num};
   assign tick    = !hold && (sum >= {1'b0, den});
   assign cfg_bad = (cfg_num == '0) || (cfg_den == '0) || (cfg_num > cfg_den);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (pause_req) state_nxt = DRAIN;
         DRAIN:   if (!pause_req) state_nxt = RUN;
                  else if (fire_a) state_nxt = PAUSED;
         PAUSED:  if (!pause_req) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge ref_clk) begin
      if (!reset_n) begin
         state       <= RUN;
         num         <= ACC_W'(NUM_DEF);
         den         <= ACC_W'(DEN_DEF);
         acc         <= '0;
         sh_num      <= '0;
         sh_den      <= '0;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
         pause_ack   <= 1'b0;
         cen_base    <= 1'b0;
      end else begin
         state     <= state_nxt;
         pause_ack <= hold;
         cen_base  <= tick;
         cfg_err   <= cfg_we && cfg_bad;
         if (!hold)
            acc <= tick ? ACC_W'(sum - {1'b0, den}) : sum[ACC_W-1:0];
         // The current tick finishes on the old rate; the new rate starts from phase 0.
         if (cfg_pending && (tick || hold)) begin
            num         <= sh_num;
            den         <= sh_den;
            acc         <= '0;
            cfg_pending <= 1'b0;
         end
         if (cfg_we && !cfg_bad) begin
            sh_num      <= cfg_num;
            sh_den      <= cfg_den;
            cfg_pending <= 1'b1;
         end
      end
   end

   cen_chan #(.DIV(DIV_A), .OFFSET(OFF_A)) u_chan_a (
      .ref_clk(ref_clk), .reset_n(reset_n), .tick(tick), .hold(hold),
      .cen(cen_a), .fire(fire_a));

   cen_chan #(.DIV(DIV_B), .OFFSET(OFF_B)) u_chan_b (
      .ref_clk(ref_clk), .reset_n(reset_n), .tick(tick), .hold(hold),
      .cen(cen_b), .fire(unused_fire_b));

   cen_chan #(.DIV(DIV_C), .OFFSET(OFF_C)) u_chan_c (
      .ref_clk(ref_clk), .reset_n(reset_n), .tick(tick), .hold(hold),
      .cen(cen_c), .fire(unused_fire_c));

endmodule

// File: tb/tb_cen_scheduler.sv
// Scoreboard bench: expected enable events are queued up front and matched
// against the DUT outputs cycle by cycle.
module tb_cen_scheduler;

   typedef struct {
      int         cyc;
      logic [3:0] bits;   // {cen_base, cen_a, cen_b, cen_c}
   } ev_t;

   logic        ref_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic        pause_req = 1'b0;
   logic [15:0] cfg_num = '0;
   logic [15:0] cfg_den = '0;

   logic pend1, err1, ack1, base1, ca1, cb1, cc1;
   logic pend2, err2, ack2, base2, ca2, cb2, cc2;

   int  cyc;
   int  checks;
   int  passes;
   ev_t q[$];

   cen_scheduler dut1 (
      .ref_clk(ref_clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_num(cfg_num),
      .cfg_den(cfg_den), .cfg_pending(pend1), .cfg_err(err1), .pause_req(pause_req),
      .pause_ack(ack1), .cen_base(base1), .cen_a(ca1), .cen_b(cb1), .cen_c(cc1));

   cen_scheduler #(.DIV_A(2)) dut2 (
      .ref_clk(ref_clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_num(cfg_num),
      .cfg_den(cfg_den), .cfg_pending(pend2), .cfg_err(err2), .pause_req(pause_req),
      .pause_ack(ack2), .cen_base(base2), .cen_a(ca2), .cen_b(cb2), .cen_c(cc2));

   always #5 ref_clk = ~ref_clk;

   task automatic step;
      @(posedge ref_clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset;
      reset_n   = 1'b0;
      pause_req = 1'b0;
      cfg_we    = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      cyc = 0;
      q.delete();
   endtask

   // idx is the 1-based base-tick count since reset; channel B divides by 2, C by 4.
   task automatic push_ev(input int c, input int idx, input int diva);
      ev_t e;
      e.cyc  = c;
      e.bits = {1'b1, (idx % diva) == 0, (idx % 2) == 0, (idx % 4) == 0};
      q.push_back(e);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      step();
      step();
      checks++;
      if ({base1, ca1, cb1, cc1, ack1, pend1, err1} !== 7'b0)
         $display("FAIL reset_dut1 got=%b exp=0000000", {base1, ca1, cb1, cc1, ack1, pend1, err1});
      else passes++;
      checks++;
      if ({base2, ca2, cb2, cc2, ack2, pend2, err2} !== 7'b0)
         $display("FAIL reset_dut2 got=%b exp=0000000", {base2, ca2, cb2, cc2, ack2, pend2, err2});
      else passes++;
   endtask

   task automatic test_cadence;
      logic [3:0] obs, exp;
      do_reset();
      for (int k = 1; k <= 5; k++) push_ev(12 * k, k, 1);
      for (int n = 0; n < 60; n++) begin
         step();
         obs = {base1, ca1, cb1, cc1};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].bits;
            void'(q.pop_front());
         end
         if (obs != 0 || exp != 0) begin
            checks++;
            if (obs !== exp) $display("FAIL cadence cyc=%0d got=%b exp=%b", cyc, obs, exp);
            else passes++;
         end
      end
      checks++;
      if (q.size() != 0) $display("FAIL cadence_left got=%0d exp=0", q.size());
      else passes++;
   endtask

   task automatic test_cfg_rate;
      logic [3:0] obs, exp;
      int         tcyc[10] = '{12, 15, 18, 20, 23, 26, 28, 31, 34, 36};
      do_reset();
      for (int k = 0; k < 10; k++) push_ev(tcyc[k], k + 1, 1);
      for (int n = 0; n < 36; n++) begin
         step();
         obs = {base1, ca1, cb1, cc1};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].bits;
            void'(q.pop_front());
         end
         if (obs != 0 || exp != 0) begin
            checks++;
            if (obs !== exp) $display("FAIL cfg_rate cyc=%0d got=%b exp=%b", cyc, obs, exp);
            else passes++;
         end
         if (cyc == 6 || cyc == 11) begin
            checks++;
            if (pend1 !== 1'b1) $display("FAIL cfg_pending_set cyc=%0d got=%b exp=1", cyc, pend1);
            else passes++;
         end
         if (cyc == 12) begin
            checks++;
            if (pend1 !== 1'b0) $display("FAIL cfg_pending_clr cyc=%0d got=%b exp=0", cyc, pend1);
            else passes++;
         end
         cfg_we = 1'b0;
         if (cyc == 5) begin
            cfg_we  = 1'b1;
            cfg_num = 16'd3;
            cfg_den = 16'd8;
         end
      end
      checks++;
      if (q.size() != 0) $display("FAIL cfg_rate_left got=%0d exp=0", q.size());
      else passes++;
   endtask

   task automatic test_cfg_err;
      logic [3:0] obs, exp;
      do_reset();
      push_ev(12, 1, 1);
      push_ev(24, 2, 1);
      for (int n = 0; n < 24; n++) begin
         step();
         obs = {base1, ca1, cb1, cc1};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].bits;
            void'(q.pop_front());
         end
         if (obs != 0 || exp != 0) begin
            checks++;
            if (obs !== exp) $display("FAIL cfg_err_rate cyc=%0d got=%b exp=%b", cyc, obs, exp);
            else passes++;
         end
         if (cyc == 3 || cyc == 4) begin
            checks++;
            if (err1 !== (cyc == 3)) $display("FAIL cfg_err_pulse cyc=%0d got=%b exp=%b", cyc, err1, cyc == 3);
            else passes++;
         end
         if (cyc == 3 || cyc == 24) begin
            checks++;
            if (pend1 !== 1'b0) $display("FAIL cfg_err_pending cyc=%0d got=%b exp=0", cyc, pend1);
            else passes++;
         end
         cfg_we = 1'b0;
         if (cyc == 2) begin
            cfg_we  = 1'b1;
            cfg_num = 16'd5;
            cfg_den = 16'd4;
         end
      end
      checks++;
      if (q.size() != 0) $display("FAIL cfg_err_left got=%0d exp=0", q.size());
      else passes++;
   endtask

   // DIV_A=2 instance: tick 12 is not a CPU boundary, tick 24 is.
   task automatic test_pause;
      logic [3:0] obs, exp;
      do_reset();
      push_ev(12, 1, 2);
      push_ev(24, 2, 2);
      push_ev(137, 3, 2);
      push_ev(149, 4, 2);
      for (int n = 0; n < 150; n++) begin
         step();
         obs = {base2, ca2, cb2, cc2};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].bits;
            void'(q.pop_front());
         end
         if (obs != 0 || exp != 0) begin
            checks++;
            if (obs !== exp) $display("FAIL pause_sb cyc=%0d got=%b exp=%b", cyc, obs, exp);
            else passes++;
         end
         if (cyc == 20 || cyc == 24 || cyc == 25 || cyc == 124 || cyc == 125 || cyc == 126) begin
            checks++;
            if (ack2 !== (cyc >= 25 && cyc <= 125))
               $display("FAIL pause_ack cyc=%0d got=%b exp=%b", cyc, ack2, cyc >= 25 && cyc <= 125);
            else passes++;
         end
         if (cyc == 13) pause_req = 1'b1;
         if (cyc == 124) pause_req = 1'b0;
      end
      checks++;
      if (q.size() != 0) $display("FAIL pause_left got=%0d exp=0", q.size());
      else passes++;
   endtask

   task automatic test_pause_glitch;
      logic [3:0] obs, exp;
      do_reset();
      for (int k = 1; k <= 3; k++) push_ev(12 * k, k, 1);
      for (int n = 0; n < 36; n++) begin
         step();
         obs = {base1, ca1, cb1, cc1};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].bits;
            void'(q.pop_front());
         end
         if (obs != 0 || exp != 0) begin
            checks++;
            if (obs !== exp) $display("FAIL glitch_sb cyc=%0d got=%b exp=%b", cyc, obs, exp);
            else passes++;
         end
         if (cyc >= 4 && cyc <= 14) begin
            checks++;
            if (ack1 !== 1'b0) $display("FAIL glitch_ack cyc=%0d got=%b exp=0", cyc, ack1);
            else passes++;
         end
         if (cyc == 3) pause_req = 1'b1;
         if (cyc == 6) pause_req = 1'b0;
      end
      checks++;
      if (q.size() != 0) $display("FAIL glitch_left got=%0d exp=0", q.size());
      else passes++;
   endtask

   task automatic test_reset_paused;
      logic [3:0] obs, exp;
      do_reset();
      pause_req = 1'b1;
      while (cyc < 13) step();
      cfg_we  = 1'b1;
      cfg_num = 16'd3;
      cfg_den = 16'd8;
      step();
      cfg_we = 1'b0;
      checks++;
      if ({ack1, pend1} !== 2'b11) $display("FAIL rp_pre got=%b exp=11", {ack1, pend1});
      else passes++;
      reset_n   = 1'b0;
      pause_req = 1'b0;
      step();
      checks++;
      if ({base1, ca1, cb1, cc1, ack1, pend1, err1} !== 7'b0)
         $display("FAIL rp_reset got=%b exp=0000000", {base1, ca1, cb1, cc1, ack1, pend1, err1});
      else passes++;
      reset_n = 1'b1;
      cyc = 0;
      q.delete();
      push_ev(12, 1, 1);
      push_ev(24, 2, 1);
      for (int n = 0; n < 24; n++) begin
         step();
         obs = {base1, ca1, cb1, cc1};
         exp = '0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            exp = q[0].bits;
            void'(q.pop_front());
         end
         if (obs != 0 || exp != 0) begin
            checks++;
            if (obs !== exp) $display("FAIL rp_rate cyc=%0d got=%b exp=%b", cyc, obs, exp);
            else passes++;
         end
      end
      checks++;
      if ({ack1, pend1} !== 2'b00 || q.size() != 0)
         $display("FAIL rp_after got=%b left=%0d exp=00 left=0", {ack1, pend1}, q.size());
      else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      cyc    = 0;
      test_reset();
      test_cadence();
      test_cfg_rate();
      test_cfg_err();
      test_pause();
      test_pause_glitch();
      test_reset_paused();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
